// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI command/register controller:
// FSM encoding, command-byte bit positions and the status-byte layout.
package spi_reg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        WR_DATA,
        RD_DATA
    } state_t;

    localparam int RD_BIT  = 7;
    localparam int INC_BIT = 6;

    localparam logic [3:0] STATUS_ID_DEF = 4'hA;
    localparam logic [7:0] ERR_BYTE_DEF  = 8'hEE;

    // Status byte: {id[3:0], 1'b0, overrun, underrun, 1'b1}
    localparam int STAT_OVR_BIT = 2;
    localparam int STAT_UND_BIT = 1;

    function automatic logic [7:0] status_byte(input logic [3:0] id,
                                               input logic       ovr,
                                               input logic       und);
        logic [7:0] s;
        s               = {id, 4'b0001};
        s[STAT_OVR_BIT] = ovr;
        s[STAT_UND_BIT] = und;
        return s;
    endfunction

endpackage

// File: rtl/spi_reg_ctrl_if.sv
// Register-bus interface between the SPI command controller (master) and
// the register file (slave).
interface spi_reg_ctrl_if #(
    parameter int ADDR_W = 8
);
    // Handshake: the master raises reg_req with reg_we/reg_addr/reg_wdata and
    // holds all four stable until the cycle the slave drives reg_ack; that
    // cycle completes the access (reg_rdata valid for reads) and reg_req drops
    // on the next cycle. Only one access is ever outstanding.
    logic              reg_req;
    logic              reg_we;
    logic [ADDR_W-1:0] reg_addr;
    logic [7:0]        reg_wdata;
    logic              reg_ack;
    logic [7:0]        reg_rdata;

    modport master (
        output reg_req, reg_we, reg_addr, reg_wdata,
        input  reg_ack, reg_rdata
    );

    modport slave (
        input  reg_req, reg_we, reg_addr, reg_wdata,
        output reg_ack, reg_rdata
    );
endinterface

// File: rtl/reg_bus_master.sv
// Single-outstanding register-bus request holder: a launch pulse starts an
// access the next cycle, which is held until acknowledged.
module reg_bus_master #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              launch,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    output logic              busy,
    output logic              rd_done,
    spi_reg_ctrl_if.master    bus
);

    // A launch is ignored while an access is in flight; the caller checks busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.reg_req   <= 1'b0;
            bus.reg_we    <= 1'b0;
            bus.reg_addr  <= '0;
            bus.reg_wdata <= '0;
        end else if (bus.reg_req) begin
            if (bus.reg_ack) begin
                bus.reg_req <= 1'b0;
            end
        end else if (launch) begin
            bus.reg_req   <= 1'b1;
            bus.reg_we    <= we;
            bus.reg_addr  <= addr;
            bus.reg_wdata <= wdata;
        end
    end

    assign busy    = bus.reg_req;
    assign rd_done = bus.reg_req & bus.reg_ack & ~bus.reg_we;

endmodule

// File: rtl/spi_reg_ctrl.sv
// SPI frame parser: command byte, address byte, then a write stream or a
// prefetched read stream over the register bus; owns the slave's tx byte.
module spi_reg_ctrl
    import spi_reg_pkg::*;
#(
    parameter int         ADDR_W    = 8,
    parameter logic [3:0] STATUS_ID = STATUS_ID_DEF,
    parameter logic [7:0] ERR_BYTE  = ERR_BYTE_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           sv_valid,
    input  logic [7:0]     sv_rx_data,
    input  logic           sv_read,
    input  logic           sv_busy,
    output logic [7:0]     sv_tx_data,
    output logic           err_ovr,
    output logic           err_und,
    output state_t         dbg_state,
    spi_reg_ctrl_if.master bus
);

    state_t            state, state_nxt;
    logic              busy_q;
    logic              cmd_rd, cmd_inc;
    logic              rd_pend, tx_full;
    logic [ADDR_W-1:0] addr, addr_inc, rx_addr;
    logic [7:0]        tx_buf;

    logic              frame_start, frame_end, byte_in;
    logic              wr_launch, wr_drop, rd_now, rd_defer, rd_retry;
    logic              data_read, status_read, und_evt, capture;
    logic              launch, bm_busy, rd_done;
    logic [ADDR_W-1:0] launch_addr;

    assign frame_start = sv_busy & ~busy_q;
    assign frame_end   = ~sv_busy & busy_q;
    assign byte_in     = sv_valid & ~frame_end;
    assign rx_addr     = sv_rx_data[ADDR_W-1:0];
    assign addr_inc    = addr + ADDR_W'(cmd_inc);

    assign wr_launch = (state == WR_DATA) & byte_in & ~bm_busy;
    assign wr_drop   = (state == WR_DATA) & byte_in & bm_busy;
    assign rd_now    = (state == ADDR) & byte_in & cmd_rd & ~bm_busy;
    assign rd_defer  = (state == ADDR) & byte_in & cmd_rd & bm_busy;
    assign rd_retry  = (state == RD_DATA) & rd_pend & ~bm_busy & ~frame_end;

    assign data_read   = sv_read & (state == RD_DATA);
    assign status_read = sv_read & (state != RD_DATA);
    assign und_evt     = data_read & ~tx_full;
    // While a re-read is pending, whatever is in flight is for a stale address.
    assign capture     = (state == RD_DATA) & rd_done & ~rd_pend & ~frame_end;

    assign launch      = wr_launch | rd_now | rd_retry;
    assign launch_addr = (state == ADDR) ? rx_addr : addr;
    assign dbg_state   = state;

    reg_bus_master #(.ADDR_W(ADDR_W)) u_bus (
        .clk     (clk),
        .rst     (rst),
        .launch  (launch),
        .we      (wr_launch),
        .addr    (launch_addr),
        .wdata   (sv_rx_data),
        .busy    (bm_busy),
        .rd_done (rd_done),
        .bus     (bus)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (frame_end) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (frame_start) state_nxt = CMD;
                CMD:     if (sv_valid) state_nxt = ADDR;
                ADDR:    if (sv_valid) state_nxt = cmd_rd ? RD_DATA : WR_DATA;
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q     <= 1'b0;
            cmd_rd     <= 1'b0;
            cmd_inc    <= 1'b0;
            addr       <= '0;
            rd_pend    <= 1'b0;
            tx_full    <= 1'b0;
            tx_buf     <= '0;
            sv_tx_data <= '0;
            err_ovr    <= 1'b0;
            err_und    <= 1'b0;
        end else begin
            busy_q <= sv_busy;

            if ((state == CMD) && byte_in) begin
                cmd_rd  <= sv_rx_data[RD_BIT];
                cmd_inc <= sv_rx_data[INC_BIT];
            end

            if ((state == ADDR) && byte_in) begin
                addr <= rx_addr;
            end else if (wr_launch || data_read) begin
                addr <= addr_inc;
            end

            if (frame_end) begin
                rd_pend <= 1'b0;
            end else if (data_read || rd_defer) begin
                rd_pend <= 1'b1;
            end else if (rd_retry) begin
                rd_pend <= 1'b0;
            end

            if (capture) begin
                tx_buf <= bus.reg_rdata;
            end
            if (frame_end || data_read) begin
                tx_full <= 1'b0;
            end else if (capture) begin
                tx_full <= 1'b1;
            end

            if (data_read) begin
                sv_tx_data <= tx_full ? tx_buf : ERR_BYTE;
            end else if (status_read) begin
                sv_tx_data <= status_byte(STATUS_ID, err_ovr, err_und);
            end

            // A fresh error in the same cycle as a status read survives the clear.
            if (wr_drop) begin
                err_ovr <= 1'b1;
            end else if (status_read) begin
                err_ovr <= 1'b0;
            end
            if (und_evt) begin
                err_und <= 1'b1;
            end else if (status_read) begin
                err_und <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Bench for spi_reg_ctrl: SPI-slave byte driver, register-bus responder with
// programmable ack latency, and a model of expected bus accesses and tx bytes.
module tb_spi_reg_ctrl;
    import spi_reg_pkg::*;

    logic       clk;
    logic       rst;
    logic       sv_valid;
    logic [7:0] sv_rx_data;
    logic       sv_read;
    logic       sv_busy;
    logic [7:0] sv_tx_data;
    logic       err_ovr;
    logic       err_und;
    state_t     dbg_state;

    spi_reg_ctrl_if #(.ADDR_W(8)) bus ();

    spi_reg_ctrl #(.ADDR_W(8), .STATUS_ID(4'hA), .ERR_BYTE(8'hEE)) dut (
        .clk        (clk),
        .rst        (rst),
        .sv_valid   (sv_valid),
        .sv_rx_data (sv_rx_data),
        .sv_read    (sv_read),
        .sv_busy    (sv_busy),
        .sv_tx_data (sv_tx_data),
        .err_ovr    (err_ovr),
        .err_und    (err_und),
        .dbg_state  (dbg_state),
        .bus        (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // model state: sticky error flags as the spec defines them
    logic m_ovr = 1'b0;
    logic m_und = 1'b0;

    // ---------------- register-bus responder ----------------
    int          ack_delay = 1;
    int          ack_cnt   = 0;
    logic        holding   = 1'b0;
    logic [16:0] held;
    logic [16:0] cur;
    logic [16:0] obs_q[$];

    initial begin
        bus.reg_ack   = 1'b0;
        bus.reg_rdata = 8'h00;
        forever begin
            @(posedge clk); #1;
            cur = {bus.reg_we, bus.reg_addr, bus.reg_we ? bus.reg_wdata : 8'h00};
            if (bus.reg_ack) begin
                bus.reg_ack = 1'b0;
                ack_cnt     = 0;
                holding     = 1'b0;
                n_cmp++;
                if (bus.reg_req !== 1'b0) begin
                    n_fail++;
                    $display("FAIL req_drop: reg_req=%b after ack, expected 0", bus.reg_req);
                end
            end else if (bus.reg_req) begin
                if (!holding) begin
                    held    = cur;
                    holding = 1'b1;
                end
                ack_cnt++;
                if (ack_cnt >= ack_delay) begin
                    if (ack_cnt > 1) begin
                        n_cmp++;
                        if (cur !== held) begin
                            n_fail++;
                            $display("FAIL bus_hold: got %05h expected %05h", cur, held);
                        end
                    end
                    bus.reg_ack   = 1'b1;
                    bus.reg_rdata = bus.reg_addr ^ 8'h5A;
                    obs_q.push_back(cur);
                end
            end else begin
                ack_cnt = 0;
                holding = 1'b0;
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic spi_read(output logic [7:0] b);
        sv_read = 1'b1;
        tick();
        sv_read = 1'b0;
        b = sv_tx_data;
    endtask

    task automatic send_byte(input logic [7:0] b, input int spacing);
        sv_valid   = 1'b1;
        sv_rx_data = b;
        tick();
        sv_valid = 1'b0;
        gap(spacing);
    endtask

    function automatic logic [7:0] exp_status();
        return {4'hA, 1'b0, m_ovr, m_und, 1'b1};
    endfunction

    // first byte of each frame is the status byte, strobed before busy rises
    task automatic start_frame(input string tag);
        logic [7:0] b;
        logic [7:0] e;
        e = exp_status();
        spi_read(b);
        n_cmp++;
        if (b !== e) begin
            n_fail++;
            $display("FAIL status_%s: got %02h expected %02h", tag, b, e);
        end
        m_ovr   = 1'b0;
        m_und   = 1'b0;
        sv_busy = 1'b1;
        gap(3);
    endtask

    task automatic end_frame();
        sv_busy = 1'b0;
        gap(3);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        gap(3);
        n_cmp += 8;
        if (sv_tx_data !== 8'h00) begin n_fail++; $display("FAIL rst_tx: got %02h expected 00", sv_tx_data); end
        if (bus.reg_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b expected 0", bus.reg_req); end
        if (bus.reg_we !== 1'b0) begin n_fail++; $display("FAIL rst_we: got %b expected 0", bus.reg_we); end
        if (bus.reg_addr !== 8'h00) begin n_fail++; $display("FAIL rst_addr: got %02h expected 00", bus.reg_addr); end
        if (bus.reg_wdata !== 8'h00) begin n_fail++; $display("FAIL rst_wdata: got %02h expected 00", bus.reg_wdata); end
        if (err_ovr !== 1'b0) begin n_fail++; $display("FAIL rst_ovr: got %b expected 0", err_ovr); end
        if (err_und !== 1'b0) begin n_fail++; $display("FAIL rst_und: got %b expected 0", err_und); end
        if (dbg_state !== IDLE) begin n_fail++; $display("FAIL rst_state: got %0d expected %0d", dbg_state, IDLE); end
        rst = 1'b0;
        gap(2);
    endtask

    task automatic test_idle_read();
        start_frame("idle");
        end_frame();
        start_frame("idle2");
        end_frame();
    endtask

    task automatic test_write_burst();
        logic [16:0] exp_q[$];
        logic [7:0]  fixed_d[2];
        logic [7:0]  a, d, cmd;
        logic        inc;
        int          n;
        fixed_d[0] = 8'h55;
        fixed_d[1] = 8'h66;
        obs_q.delete();
        for (int k = 0; k < 5; k++) begin
            if (k == 0) begin
                cmd = 8'h40; a = 8'h10; inc = 1'b1; n = 2; ack_delay = 1;
            end else begin
                inc = 1'($urandom_range(0, 1));
                cmd = {1'b0, inc, 6'($urandom)};
                a   = 8'($urandom_range(0, 255));
                n   = $urandom_range(1, 5);
                ack_delay = $urandom_range(1, 4);
            end
            start_frame("wr");
            send_byte(cmd, 8);
            send_byte(a, 8);
            for (int i = 0; i < n; i++) begin
                d = (k == 0) ? fixed_d[i] : 8'($urandom);
                send_byte(d, 8);
                exp_q.push_back({1'b1, 8'(a + i * inc), d});
            end
            end_frame();
        end
        n_cmp++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL wr_count: got %0d expected %0d", obs_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_cmp++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL wr_access[%0d]: got %05h expected %05h", i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_read_burst();
        logic [16:0] exp_q[$];
        logic [7:0]  a, b, e, cmd;
        logic        inc;
        int          n;
        obs_q.delete();
        for (int k = 0; k < 5; k++) begin
            if (k == 0) begin
                cmd = 8'hC0; a = 8'hFE; inc = 1'b1; n = 3; ack_delay = 1;
            end else begin
                inc = 1'($urandom_range(0, 1));
                cmd = {1'b1, inc, 6'($urandom)};
                a   = 8'($urandom_range(0, 255));
                n   = $urandom_range(1, 5);
                ack_delay = $urandom_range(1, 4);
            end
            start_frame("rd");
            send_byte(cmd, 8);
            send_byte(a, 8);
            for (int i = 0; i < n; i++) begin
                e = 8'(a + i * inc) ^ 8'h5A;
                spi_read(b);
                n_cmp++;
                if (b !== e) begin
                    n_fail++;
                    $display("FAIL rd_byte[%0d]: got %02h expected %02h", i, b, e);
                end
                gap(8);
                n_cmp++;
                if (sv_tx_data !== e) begin
                    n_fail++;
                    $display("FAIL tx_hold: got %02h expected %02h", sv_tx_data, e);
                end
            end
            for (int i = 0; i <= n; i++) exp_q.push_back({1'b0, 8'(a + i * inc), 8'h00});
            end_frame();
        end
        n_cmp++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL rd_count: got %0d expected %0d", obs_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_cmp++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL rd_access[%0d]: got %05h expected %05h", i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_underrun();
        logic [7:0] b;
        ack_delay = 40;
        obs_q.delete();
        start_frame("und");
        send_byte(8'h80, 1);
        send_byte(8'h20, 0);
        gap(8);
        spi_read(b);
        n_cmp += 2;
        if (b !== 8'hEE) begin n_fail++; $display("FAIL und_byte: got %02h expected EE", b); end
        if (err_und !== 1'b1) begin n_fail++; $display("FAIL und_flag: got %b expected 1", err_und); end
        m_und = 1'b1;
        gap(60);
        end_frame();
        gap(100);
        n_cmp++;
        if (obs_q.size() !== 2 || obs_q[0] !== {1'b0, 8'h20, 8'h00} || obs_q[1] !== {1'b0, 8'h20, 8'h00}) begin
            n_fail++;
            $display("FAIL und_reads: got %0d accesses expected 2 reads of 20", obs_q.size());
        end
        ack_delay = 1;
        start_frame("und_report");
        n_cmp++;
        if (err_und !== 1'b0) begin n_fail++; $display("FAIL und_clear: got %b expected 0", err_und); end
        end_frame();
        start_frame("und_after");
        end_frame();
    endtask

    task automatic test_overrun();
        ack_delay = 30;
        obs_q.delete();
        start_frame("ovr");
        send_byte(8'h00, 2);
        send_byte(8'h33, 2);
        send_byte(8'h11, 8);
        send_byte(8'h22, 3);
        n_cmp++;
        if (err_ovr !== 1'b1) begin n_fail++; $display("FAIL ovr_flag: got %b expected 1", err_ovr); end
        m_ovr = 1'b1;
        gap(40);
        end_frame();
        n_cmp++;
        if (obs_q.size() !== 1 || obs_q[0] !== {1'b1, 8'h33, 8'h11}) begin
            n_fail++;
            $display("FAIL ovr_writes: got %0d accesses expected 1 write 33<-11", obs_q.size());
        end
        ack_delay = 1;
        start_frame("ovr_report");
        n_cmp++;
        if (err_ovr !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %b expected 0", err_ovr); end
        end_frame();
    endtask

    task automatic test_abort();
        logic [7:0] b;
        ack_delay = 20;
        start_frame("abort");
        send_byte(8'h80, 1);
        send_byte(8'h44, 2);
        end_frame();
        n_cmp++;
        if (dbg_state !== IDLE) begin n_fail++; $display("FAIL abort_state: got %0d expected %0d", dbg_state, IDLE); end
        gap(30);
        n_cmp += 2;
        if (dbg_state !== IDLE) begin n_fail++; $display("FAIL abort_idle: got %0d expected %0d", dbg_state, IDLE); end
        if (sv_tx_data !== 8'hA1) begin n_fail++; $display("FAIL abort_tx: got %02h expected A1", sv_tx_data); end
        // stale prefetch must not leak into the next read frame
        start_frame("abort_next");
        send_byte(8'hC0, 1);
        send_byte(8'h50, 3);
        spi_read(b);
        n_cmp++;
        if (b !== 8'hEE) begin n_fail++; $display("FAIL abort_und: got %02h expected EE", b); end
        m_und = 1'b1;
        gap(50);
        spi_read(b);
        n_cmp++;
        if (b !== (8'h51 ^ 8'h5A)) begin n_fail++; $display("FAIL abort_rd: got %02h expected %02h", b, 8'h51 ^ 8'h5A); end
        end_frame();
        gap(30);
    endtask

    task automatic test_reset_mid_read();
        logic [7:0] b;
        ack_delay = 20;
        start_frame("rst_mid");
        send_byte(8'hC0, 1);
        send_byte(8'h60, 2);
        spi_read(b);
        n_cmp++;
        if (b !== 8'hEE) begin n_fail++; $display("FAIL rstmid_und: got %02h expected EE", b); end
        gap(2);
        rst     = 1'b1;
        sv_busy = 1'b0;
        tick();
        n_cmp += 5;
        if (sv_tx_data !== 8'h00) begin n_fail++; $display("FAIL rstmid_tx: got %02h expected 00", sv_tx_data); end
        if (bus.reg_req !== 1'b0) begin n_fail++; $display("FAIL rstmid_req: got %b expected 0", bus.reg_req); end
        if (bus.reg_addr !== 8'h00) begin n_fail++; $display("FAIL rstmid_addr: got %02h expected 00", bus.reg_addr); end
        if (err_und !== 1'b0) begin n_fail++; $display("FAIL rstmid_und_flag: got %b expected 0", err_und); end
        if (dbg_state !== IDLE) begin n_fail++; $display("FAIL rstmid_state: got %0d expected %0d", dbg_state, IDLE); end
        rst   = 1'b0;
        m_und = 1'b0;
        m_ovr = 1'b0;
        ack_delay = 1;
        gap(5);
        start_frame("after_rst");
        end_frame();
    endtask

    initial begin
        rst        = 1'b1;
        sv_valid   = 1'b0;
        sv_rx_data = 8'h00;
        sv_read    = 1'b0;
        sv_busy    = 1'b0;
        test_reset();
        test_idle_read();
        test_write_burst();
        test_read_burst();
        test_underrun();
        test_overrun();
        test_abort();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_reg_ctrl.md
Name: spi_reg_ctrl

Overview:
- Command/register controller placed behind the SPI slave byte interface (byte-valid/rx, read-strobe/tx, busy).
- Parses each SPI frame as a command byte, an address byte, then a data-byte stream.
- Drives a simple 8-bit register-bus master to perform writes and prefetched reads.
- Owns the slave's tx_data, so every outgoing byte is stable in the cycle after the slave's read strobe.

Parameters:
ADDR_W, 8, register address width (1..8); address = low ADDR_W bits of address byte
STATUS_ID, 4'hA, upper nibble of status byte returned as first frame byte
ERR_BYTE, 8'hEE, byte returned when read prefetch has not completed (underrun)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
sv_valid  in  1  slave: one-cycle pulse, sv_rx_data holds a complete received byte
sv_rx_data  in  8  slave: received byte
sv_read  in  1  slave: one-cycle pulse, slave samples sv_tx_data in the following cycle
sv_busy  in  1  slave: high while ss_n asserted (frame active)
sv_tx_data  out  8  byte to slave shift register
reg_req  out  1  register access request, held until reg_ack
reg_we  out  1  1=write, 0=read; stable while reg_req
reg_addr  out  ADDR_W  access address; stable while reg_req
reg_wdata  out  8  write data; stable while reg_req
reg_ack  in  1  access accepted/completed this cycle (read data valid same cycle)
reg_rdata  in  8  read data, valid with reg_ack
err_ovr  out  1  sticky: write byte dropped (previous write still pending)
err_und  out  1  sticky: ERR_BYTE sent (read prefetch not ready)

Behaviour:
- Reset (sync, rst=1): state IDLE, sv_tx_data=0, reg_req=0, reg_we=0, reg_addr=0, reg_wdata=0, tx_full=0, err_ovr=0, err_und=0.
- Frame start = sv_busy rising (registered prev value). Frame end = sv_busy falling.
- Command byte: bit7 = RD (1 read, 0 write); bit6 = INC (auto-increment address); bits5:0 ignored.
- FSM states: IDLE, CMD, ADDR, WR_DATA, RD_DATA.
  - IDLE: frame start -> CMD.
  - CMD: sv_valid latches RD/INC -> ADDR.
  - ADDR: sv_valid latches addr. If RD: launch read at addr, -> RD_DATA. Else -> WR_DATA.
  - WR_DATA: each sv_valid with no request pending launches write (addr, byte); then addr += INC.
    - sv_valid while a request is pending: byte dropped, err_ovr<=1.
  - RD_DATA: incoming bytes ignored.
    - On reg_ack of a read: tx_buf<=reg_rdata, tx_full<=1.
    - On sv_read: sv_tx_data<=(tx_full ? tx_buf : ERR_BYTE); err_und<=1 if !tx_full; tx_full<=0; addr += INC.
    - Next cycle: launch read of the new addr. Re-reads the same addr if INC=0.
  - Any state, frame end -> IDLE. Frame end has priority over sv_valid in the same cycle.
- sv_read outside RD_DATA (IDLE/CMD/ADDR/WR_DATA): sv_tx_data <= status = {STATUS_ID, 1'b0, err_ovr, err_und, 1'b1}; err_ovr/err_und cleared in that same cycle.
  - A new error event in the same cycle wins (flag stays set).
  - Covers the frame's first byte: the slave strobes read before sv_busy rises.
- sv_tx_data changes only in the cycle after an sv_read pulse (registered update), never otherwise.
- Bus handshake: reg_req rises the cycle after launch and stays high with stable reg_we/addr/wdata until the reg_ack cycle; it drops the next cycle. At most one outstanding access.
- Frame end or state change with a request pending: the request completes (no abort on bus). Read data returned after frame end is discarded; tx_full is cleared at frame end.
- New frame while a request is still pending: writes follow the overrun rule above; a read launch is deferred until the pending ack.
- Address arithmetic: modulo 2^ADDR_W; 0xFF+1 -> 0x00 for ADDR_W=8.
- Timing constraint (system-level, documented): read ack latency must be below half an SCLK period plus 2 clk, otherwise underrun occurs.

Decomposition:
- Package spi_reg_pkg: state enum (IDLE, CMD, ADDR, WR_DATA, RD_DATA), command bit positions RD_BIT=7 and INC_BIT=6, default STATUS_ID/ERR_BYTE constants, status-byte field layout.
- One sub-module, reg_bus_master: single-outstanding req/ack holder with launch input, busy output, and rdata capture strobe.

Test Plan:
- Idle read: frame with no bytes beyond the first; sv_read pulse -> next cycle sv_tx_data=8'hA1 (errors clear).
- Write burst: bytes 0x40, 0x10, 0x55, 0x66, ack in 1 cycle -> writes (0x10,0x55), (0x11,0x66); reg_req held until ack.
- Read burst: bytes 0xC0, 0xFE; rdata = addr^0x5A; prefetch before each sv_read -> tx bytes 0xA4 (from 0xFE), 0xA5 (from 0xFF), then 0x5A (addr wraps to 0x00).
- Underrun: 0x80/0x20 with ack delayed 40 cycles, sv_read at +10 -> sv_tx_data=0xEE, err_und=1; next frame's status = 0xA3, then cleared.
- Overrun: write frame with reg_ack held low 30 cycles, two data bytes 8 cycles apart -> second dropped, err_ovr=1, exactly one write issued.
- Abort/reset: sv_busy falls after the address byte with a read pending -> IDLE, ack data discarded, tx_full=0; rst asserted mid-RD_DATA -> all outputs reset the next cycle.
